// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Brief    : Oversampling UART receive deframer with majority-vote sampling,
//            optional even/odd parity check and stop-bit check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk_rx,
    input  logic                  rst_rx,
    input  logic                  rx_in_rx,
    input  logic                  par_en_rx,
    input  logic                  par_typ_rx,
    output logic [DATA_WIDTH-1:0] p_data_rx,
    output logic                  data_valid_rx,
    output logic                  par_err_rx,
    output logic                  stp_err_rx,
    output logic                  busy_rx
);

    localparam int EW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EW-1:0] c_samp0 = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] c_samp1 = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] c_samp2 = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [EW-1:0] c_elast = EW'(OVERSAMPLE - 1);
    localparam logic [EW-1:0] c_eone  = EW'(1);
    localparam logic [BW-1:0] c_blast = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] c_bone  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [EW-1:0]         r_edge;
    logic [BW-1:0]         r_bit;
    logic                  r_s0;
    logic                  r_s1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_perr;
    logic                  r_serr;

    logic w_rxs;
    logic w_vote;
    logic w_decide;
    logic w_wrap;

    assign w_rxs    = r_sync2;
    // Third sample is taken live at the decision tick, so the vote resolves there.
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_decide = (r_edge == c_samp2);
    assign w_wrap   = (r_edge == c_elast);

    always_ff @(posedge clk_rx) begin
        if (rst_rx) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_edge    <= '0;
            r_bit     <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bad <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_serr    <= 1'b0;
        end else begin
            r_sync1 <= rx_in_rx;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_serr  <= 1'b0;

            if (r_state != S_IDLE) begin
                r_edge <= w_wrap ? '0 : r_edge + c_eone;
                if (r_edge == c_samp0) r_s0 <= w_rxs;
                if (r_edge == c_samp1) r_s1 <= w_rxs;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state   <= S_START;
                        r_edge    <= '0;
                        r_bit     <= '0;
                        r_par_en  <= par_en_rx;
                        r_par_typ <= par_typ_rx;
                        r_par_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_decide && w_vote) begin
                        r_state <= S_IDLE;
                        r_edge  <= '0;
                    end else if (w_wrap) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_decide) r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                    if (w_wrap) begin
                        if (r_bit == c_blast) begin
                            r_bit   <= '0;
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit <= r_bit + c_bone;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_decide) r_par_bad <= (w_vote != ((^r_shift) ^ r_par_typ));
                    if (w_wrap) r_state <= S_STOP;
                end
                S_STOP: begin
                    // Resolving mid-bit leaves half a bit to catch a back-to-back start edge.
                    if (w_decide) begin
                        r_state <= S_IDLE;
                        r_edge  <= '0;
                        if (!w_vote) begin
                            r_serr <= 1'b1;
                        end else if (r_par_bad) begin
                            r_perr <= 1'b1;
                        end else begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_edge  <= '0;
                end
            endcase
        end
    end

    assign p_data_rx     = r_data;
    assign data_valid_rx = r_valid;
    assign par_err_rx    = r_perr;
    assign stp_err_rx    = r_serr;
    assign busy_rx       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module   : tb_uart_rx_frame
// Brief    : Directed, table-driven bench for the UART receive deframer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    localparam int DW = 8;
    localparam int OS = 8;

    logic          clk_rx = 1'b0;
    logic          rst_rx;
    logic          rx_in_rx;
    logic          par_en_rx;
    logic          par_typ_rx;
    logic [DW-1:0] p_data_rx;
    logic          data_valid_rx;
    logic          par_err_rx;
    logic          stp_err_rx;
    logic          busy_rx;

    uart_rx_frame #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk_rx        (clk_rx),
        .rst_rx        (rst_rx),
        .rx_in_rx      (rx_in_rx),
        .par_en_rx     (par_en_rx),
        .par_typ_rx    (par_typ_rx),
        .p_data_rx     (p_data_rx),
        .data_valid_rx (data_valid_rx),
        .par_err_rx    (par_err_rx),
        .stp_err_rx    (stp_err_rx),
        .busy_rx       (busy_rx)
    );

    always #5 clk_rx = ~clk_rx;

    int cyc = 0;
    always @(posedge clk_rx) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int            nv = 0;
    int            np = 0;
    int            ns = 0;
    int            last_v_cyc = 0;
    logic [DW-1:0] cap [0:31];
    always @(negedge clk_rx) begin
        if (data_valid_rx) begin
            if (nv < 32) cap[nv] = p_data_rx;
            nv = nv + 1;
            last_v_cyc = cyc;
        end
        if (par_err_rx) np = np + 1;
        if (stp_err_rx) ns = ns + 1;
    end

    int total = 0;
    int bad   = 0;
    int t_start;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in_rx = b;
        repeat (OS) tick();
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit,
                              input logic stop, input int idle);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (par_en_rx) drive_bit(pbit);
        drive_bit(stop);
        rx_in_rx = 1'b1;
        repeat (idle) tick();
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        logic          pbit;
        logic          stop;
        int            ev;
        int            ep;
        int            es;
        logic [DW-1:0] edata;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int bv, bp, bs, n;
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 8'hA5};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'h3C};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'h3C};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
        vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hFF};

        rst_rx = 1'b1; rx_in_rx = 1'b1; par_en_rx = 1'b0; par_typ_rx = 1'b0;
        repeat (3) @(posedge clk_rx);
        #1;
        rst_rx = 1'b0;
        repeat (100) tick();
        check("reset_pdata", int'(p_data_rx), 0);
        check("reset_busy", int'(busy_rx), 0);
        check("reset_valid", int'(data_valid_rx), 0);
        check("idle_valid_cnt", nv, 0);
        check("idle_perr_cnt", np, 0);
        check("idle_serr_cnt", ns, 0);

        for (int i = 0; i < 8; i++) begin
            bv = nv; bp = np; bs = ns;
            par_en_rx  = vecs[i].pe;
            par_typ_rx = vecs[i].pt;
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stop, 3 * OS);
            check($sformatf("v%0d_valid", i), nv - bv, vecs[i].ev);
            check($sformatf("v%0d_perr", i), np - bp, vecs[i].ep);
            check($sformatf("v%0d_serr", i), ns - bs, vecs[i].es);
            check($sformatf("v%0d_pdata", i), int'(p_data_rx), int'(vecs[i].edata));
            if (vecs[i].ev == 1) begin
                n = 2 + DW + int'(vecs[i].pe);
                check($sformatf("v%0d_latency", i), last_v_cyc - t_start,
                      3 + (n - 1) * OS + OS / 2 + 2);
            end
        end

        // Two-cycle glitch on an idle line.
        par_en_rx = 1'b0; par_typ_rx = 1'b0;
        bv = nv; bp = np; bs = ns;
        rx_in_rx = 1'b0;
        tick(); tick();
        rx_in_rx = 1'b1;
        tick();
        check("glitch_busy_high", int'(busy_rx), 1);
        repeat (3 * OS) tick();
        check("glitch_busy_low", int'(busy_rx), 0);
        check("glitch_valid", nv - bv, 0);
        check("glitch_perr", np - bp, 0);
        check("glitch_serr", ns - bs, 0);

        // Back-to-back frames, no idle between them.
        bv = nv; bp = np; bs = ns;
        send_frame(8'h01, 1'b0, 1'b1, 0);
        send_frame(8'hFE, 1'b0, 1'b1, 3 * OS);
        check("b2b_valid", nv - bv, 2);
        check("b2b_first", int'(cap[bv]), 8'h01);
        check("b2b_second", int'(cap[bv+1]), 8'hFE);
        check("b2b_errs", (np - bp) + (ns - bs), 0);

        // Reset during data bit 4 aborts silently.
        bv = nv; bp = np; bs = ns;
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        rx_in_rx = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", int'(busy_rx), 1);
        rst_rx = 1'b1;
        tick();
        check("abort_busy_after", int'(busy_rx), 0);
        rst_rx = 1'b0;
        rx_in_rx = 1'b1;
        repeat (3 * OS) tick();
        check("abort_pulses", (nv - bv) + (np - bp) + (ns - bs), 0);
        check("abort_busy_idle", int'(busy_rx), 0);
        check("abort_pdata", int'(p_data_rx), 0);

        // Break: line held low for three frame times.
        bv = nv; bp = np; bs = ns;
        rx_in_rx = 1'b0;
        repeat (240) tick();
        rx_in_rx = 1'b1;
        repeat (4 * OS) tick();
        check("break_serr", ns - bs, 3);
        check("break_valid", nv - bv, 0);
        check("break_perr", np - bp, 0);
        check("break_busy", int'(busy_rx), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive-side deframer, the counterpart of the TX serializer/parity path.
- Oversamples the serial line, detects the start bit, shifts in DATA_WIDTH bits LSB-first, checks the optional parity bit and the stop bit, and presents the parallel byte with a one-cycle valid pulse.
- Sits between the pad-side rx line and the RX FIFO/consumer.
- Parity semantics match TX: par_typ=0 means even parity, par_typ=1 means odd parity.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- OVERSAMPLE, 8, clk_rx cycles per bit. Must be even and at least 4.

Ports:
- clk_rx  in  1  oversample clock; one tick = 1/OVERSAMPLE bit.
- rst_rx  in  1  synchronous, active-high reset.
- rx_in_rx  in  1  asynchronous serial line; idles high.
- par_en_rx  in  1  1 = frame carries a parity bit.
- par_typ_rx  in  1  0 = even parity, 1 = odd parity.
- p_data_rx  out  DATA_WIDTH  last good received word.
- data_valid_rx  out  1  one-cycle pulse when p_data_rx is updated.
- par_err_rx  out  1  one-cycle pulse on parity mismatch.
- stp_err_rx  out  1  one-cycle pulse when the stop bit samples 0.
- busy_rx  out  1  high while state is not IDLE.

Behaviour:
- Reset (synchronous, rst_rx=1 at posedge):
  - State goes to IDLE; all counters go to 0.
  - The two-flop synchronizer on rx_in_rx resets to 1.
  - p_data_rx=0; data_valid_rx, par_err_rx, stp_err_rx and busy_rx are 0.
  - Reset mid-frame aborts the frame with no pulses.
- Input path:
  - rx_in_rx passes through a 2-flop synchronizer.
  - All logic uses the synchronized value rxs.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 and wraps.
  - bit_cnt runs 0..DATA_WIDTH-1.
- Sampling (majority vote):
  - Samples are taken at edge_cnt = M-1, M, M+1, where M = OVERSAMPLE/2.
  - The majority of the three is the bit value, resolved at edge_cnt = M+1.
- Per-frame configuration: par_en_rx and par_typ_rx are latched on the IDLE->START transition. Changes mid-frame are ignored.
- FSM:
  - IDLE: when rxs=0, go to START with edge_cnt=0 and assert busy.
  - START: at decision, if the voted bit is 1 (glitch), go to IDLE with no pulses. Otherwise continue to DATA at edge_cnt wrap.
  - DATA: at each decision, shift the voted bit into the MSB of the shift register (LSB-first reception). After bit DATA_WIDTH-1, go to PARITY if parity is latched enabled, else to STOP.
  - PARITY: at decision, set exp = (^shift) XOR par_typ_latched. The parity error flag is set when the voted bit differs from exp.
  - STOP: resolved at decision (edge_cnt = M+1), not at bit end, so back-to-back frames are caught.
- STOP outcomes, registered and visible the cycle after the decision; state returns to IDLE in that same cycle:
  - Voted stop bit = 0: stp_err_rx pulses.
  - Else, parity error flag set: par_err_rx pulses.
  - Else: p_data_rx <= shift and data_valid_rx pulses.
  - Errors never update p_data_rx, and at most one of the three pulses fires per frame.
- Latency: N = 1 + DATA_WIDTH + par_en + 1. The pulse appears (N-1)*OVERSAMPLE + M + 2 cycles after START entry.
- Break condition: line held low after a stop error re-enters START immediately. Each following all-zero frame reports stp_err_rx.
- Back-to-back frames: a start edge arriving M-2 cycles after a stop decision must be received correctly.

Test Plan:
- Reset and idle: hold rst_rx=1 for 3 cycles, then rx_in_rx=1 for 100 cycles -> all outputs 0, busy_rx=0.
- Clean frame: OVERSAMPLE=8, par_en=0; send 0xA5 LSB-first (1,0,1,0,0,1,0,1), then stop=1 -> p_data_rx=0xA5, one data_valid_rx pulse, no error pulses.
- Parity, even: par_en=1, par_typ=0, 0xA5 with parity bit 0 -> valid pulse, p_data_rx=0xA5.
- Parity mismatch: same frame with par_typ=1 and parity bit 0 -> par_err_rx pulse, no valid pulse, p_data_rx holds its previous value.
- Stop error: send 0x3C with stop=0 -> stp_err_rx pulse only.
- Start glitch, back-to-back, and reset abort:
  - A 2-cycle low pulse on an idle line -> returns to IDLE, no pulses.
  - Frames 0x01 and 0xFE sent with no idle gap -> two valid pulses, 0x01 then 0xFE.
  - rst_rx asserted during bit 4 -> no pulses, busy_rx=0 on the next cycle.
